// File: rtl/noc_local_inject.sv
`timescale 1ns/1ps
// noc_local_inject
// Injection stage for the local port (port 4) of the 5-port, 2-VC mesh router.
// Takes packet commands and 32-bit payload words from the core and builds
// 35-bit flits for the router input. It can sustain one flit per cycle.
//
// Flit format: [34:33] type (01 head, 00 body, 10 tail, 11 single),
//              [32] VC, [31:0] payload.
// Head payload: [11:8] LEN, [7:6] src X, [5:4] src Y, [3:2] dst X,
//               [1:0] dst Y. All other bits are zero.
//
// Ports
//   clk, RST_            clock; synchronous active-low reset
//   MY_XPOS/MY_YPOS      this node's coordinates, sampled when a command is accepted
//   CMD_*                packet command handshake (dst, VC, LEN 0..15)
//   WDATA/WVALID/WREADY  payload word handshake
//   ODATA/OVALID/OVCH    flit to router IDATA_4/IVALID_4/IVCH_4
//   IRDY                 router ORDY_4, one ready bit per VC
//   BUSY                 packet in progress or flit pending
//   FLIT_CNT/PKT_CNT     wrapping counts of transferred flits and packets
//
// state | meaning
// IDLE  | waiting for a command; CMD_READY follows output-register space
// BODY  | streaming payload words; rem words still to send
module noc_local_inject (
  input  logic        clk,
  input  logic        RST_,
  input  logic [1:0]  MY_XPOS,
  input  logic [1:0]  MY_YPOS,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [1:0]  CMD_DSTX,
  input  logic [1:0]  CMD_DSTY,
  input  logic        CMD_VCH,
  input  logic [3:0]  CMD_LEN,
  input  logic [31:0] WDATA,
  input  logic        WVALID,
  output logic        WREADY,
  output logic [34:0] ODATA,
  output logic        OVALID,
  output logic        OVCH,
  input  logic [1:0]  IRDY,
  output logic        BUSY,
  output logic [15:0] FLIT_CNT,
  output logic [15:0] PKT_CNT
);

  typedef enum logic {
    IDLE = 1'b0,
    BODY = 1'b1
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  rem, rem_nxt;
  logic        vc, vc_nxt;
  logic        xfer, out_free;
  logic        cmd_acc, w_acc, load;
  logic [34:0] load_flit;

  // Only the ready bit of the VC currently on the output matters.
  assign xfer     = OVALID & IRDY[OVCH];
  assign out_free = ~OVALID | xfer;
  assign load     = cmd_acc | w_acc;
  assign BUSY     = (state == BODY) | OVALID;

  always_ff @(posedge clk) begin
    if (!RST_) begin
      state <= IDLE;
      rem   <= 4'd0;
      vc    <= 1'b0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
      vc    <= vc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    vc_nxt    = vc;
    CMD_READY = 1'b0;
    WREADY    = 1'b0;
    cmd_acc   = 1'b0;
    w_acc     = 1'b0;
    load_flit = '0;
    case (state)
      IDLE: begin
        CMD_READY = RST_ & out_free;
        cmd_acc   = CMD_VALID & CMD_READY;
        if (cmd_acc) begin
          load_flit = {((CMD_LEN == 4'd0) ? 2'b11 : 2'b01), CMD_VCH, 20'd0,
                       CMD_LEN, MY_XPOS, MY_YPOS, CMD_DSTX, CMD_DSTY};
          vc_nxt    = CMD_VCH;
          rem_nxt   = CMD_LEN;
          if (CMD_LEN != 4'd0) state_nxt = BODY;
        end
      end
      BODY: begin
        WREADY = RST_ & out_free;
        w_acc  = WVALID & WREADY;
        if (w_acc) begin
          load_flit = {((rem == 4'd1) ? 2'b10 : 2'b00), vc, WDATA};
          rem_nxt   = rem - 4'd1;
          if (rem == 4'd1) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // A load can happen in the same cycle as a transfer; the new flit then
  // replaces the departing one with no bubble.
  always_ff @(posedge clk) begin
    if (!RST_) begin
      OVALID <= 1'b0;
      ODATA  <= '0;
      OVCH   <= 1'b0;
    end else if (load) begin
      OVALID <= 1'b1;
      ODATA  <= load_flit;
      OVCH   <= load_flit[32];
    end else if (xfer) begin
      OVALID <= 1'b0;
    end
  end

  // Type bit 34 is set for tail (10) and single (11) flits only.
  always_ff @(posedge clk) begin
    if (!RST_) begin
      FLIT_CNT <= 16'd0;
      PKT_CNT  <= 16'd0;
    end else if (xfer) begin
      FLIT_CNT <= FLIT_CNT + 16'd1;
      if (ODATA[34]) PKT_CNT <= PKT_CNT + 16'd1;
    end
  end

endmodule

// File: tb/tb_noc_local_inject.sv
`timescale 1ns/1ps
module tb_noc_local_inject;

  logic        clk = 1'b0;
  logic        RST_;
  logic [1:0]  MY_XPOS, MY_YPOS;
  logic        CMD_VALID, CMD_READY;
  logic [1:0]  CMD_DSTX, CMD_DSTY;
  logic        CMD_VCH;
  logic [3:0]  CMD_LEN;
  logic [31:0] WDATA;
  logic        WVALID, WREADY;
  logic [34:0] ODATA;
  logic        OVALID, OVCH;
  logic [1:0]  IRDY;
  logic        BUSY;
  logic [15:0] FLIT_CNT, PKT_CNT;

  noc_local_inject dut (
    .clk(clk), .RST_(RST_), .MY_XPOS(MY_XPOS), .MY_YPOS(MY_YPOS),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_DSTX(CMD_DSTX),
    .CMD_DSTY(CMD_DSTY), .CMD_VCH(CMD_VCH), .CMD_LEN(CMD_LEN),
    .WDATA(WDATA), .WVALID(WVALID), .WREADY(WREADY),
    .ODATA(ODATA), .OVALID(OVALID), .OVCH(OVCH), .IRDY(IRDY),
    .BUSY(BUSY), .FLIT_CNT(FLIT_CNT), .PKT_CNT(PKT_CNT)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [34:0] sb[$];
  logic [15:0] exp_flit = 16'd0;
  logic [15:0] exp_pkt  = 16'd0;
  int          run_len = 0;
  int          max_run = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
    end
  endtask

  function automatic logic [34:0] make_head(input logic [3:0] len, input logic v,
                                            input logic [1:0] sx, input logic [1:0] sy,
                                            input logic [1:0] dx, input logic [1:0] dy);
    return {((len == 4'd0) ? 2'b11 : 2'b01), v, 20'd0, len, sx, sy, dx, dy};
  endfunction

  // Scoreboard consumer: every transfer must match the oldest expected flit.
  always begin
    logic [34:0] e;
    @(negedge clk);
    #2;
    if (RST_ === 1'b1 && OVALID === 1'b1 && IRDY[OVCH] === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      chk("sb_nonempty", (sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("flit", {OVCH, ODATA}, {e[32], e});
        exp_flit++;
        if (e[34]) exp_pkt++;
      end
    end else begin
      run_len = 0;
    end
  end

  task automatic send_cmd(input logic [1:0] dx, input logic [1:0] dy,
                          input logic v, input logic [3:0] len);
    int n;
    @(negedge clk);
    WVALID = 1'b0; CMD_VALID = 1'b1;
    CMD_DSTX = dx; CMD_DSTY = dy; CMD_VCH = v; CMD_LEN = len;
    #1;
    n = 0;
    while (CMD_READY !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("cmd_ready_wait", CMD_READY, 1);
    sb.push_back(make_head(len, v, MY_XPOS, MY_YPOS, dx, dy));
    @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] d, input logic last, input logic v);
    int n;
    @(negedge clk);
    CMD_VALID = 1'b0; WVALID = 1'b1; WDATA = d;
    #1;
    n = 0;
    while (WREADY !== 1'b1 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    chk("wready_wait", WREADY, 1);
    sb.push_back({(last ? 2'b10 : 2'b00), v, d});
    @(posedge clk);
  endtask

  task automatic go_idle();
    @(negedge clk);
    CMD_VALID = 1'b0; WVALID = 1'b0;
  endtask

  task automatic send_pkt(input logic [1:0] dx, input logic [1:0] dy, input logic v,
                          input logic [3:0] len, input logic [31:0] base);
    send_cmd(dx, dy, v, len);
    for (int i = 0; i < int'(len); i++) send_word(base + 32'(i), (i == int'(len) - 1), v);
    go_idle();
  endtask

  task automatic drain();
    int n;
    @(negedge clk); #3;
    n = 0;
    while (OVALID !== 1'b0 && n < 200) begin
      @(negedge clk); #3; n++;
    end
    chk("drain_ovalid", OVALID, 0);
    chk("drain_sb_empty", sb.size(), 0);
    chk("flit_cnt_model", FLIT_CNT, exp_flit);
    chk("pkt_cnt_model", PKT_CNT, exp_pkt);
  endtask

  task automatic reset_on();
    @(negedge clk);
    RST_ = 1'b0; CMD_VALID = 1'b0; WVALID = 1'b0;
    sb.delete();
    exp_flit = 16'd0; exp_pkt = 16'd0;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [34:0] hd;
    RST_ = 1'b0; CMD_VALID = 1'b1; WVALID = 1'b1; WDATA = 32'h0;
    CMD_DSTX = 2'd0; CMD_DSTY = 2'd0; CMD_VCH = 1'b0; CMD_LEN = 4'd0;
    MY_XPOS = 2'd1; MY_YPOS = 2'd2; IRDY = 2'b11;

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cmd_ready", CMD_READY, 0);
    chk("rst_wready", WREADY, 0);
    chk("rst_ovalid", OVALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_flit_cnt", FLIT_CNT, 0);
    chk("rst_pkt_cnt", PKT_CNT, 0);
    CMD_VALID = 1'b0;
    RST_ = 1'b1;
    #1;
    chk("post_rst_cmd_ready", CMD_READY, 1);
    chk("idle_wready", WREADY, 0);
    WVALID = 1'b0;

    // Single-flit packet on VC1, src (1,2), dst (3,0)
    IRDY = 2'b10;
    send_cmd(2'd3, 2'd0, 1'b1, 4'd0);
    go_idle();
    #1;
    chk("single_odata", ODATA, 35'h7_0000_006C);
    chk("single_ovalid", OVALID, 1);
    chk("single_next_cmd_ready", CMD_READY, 1);
    drain();
    chk("single_flit_cnt", FLIT_CNT, 16'd1);
    chk("single_pkt_cnt", PKT_CNT, 16'd1);

    // Back-to-back LEN=3
    IRDY = 2'b11;
    MY_XPOS = 2'd2; MY_YPOS = 2'd3;
    max_run = 0;
    send_pkt(2'd0, 2'd1, 1'b0, 4'd3, 32'hA000_0000);
    drain();
    chk("b2b_run", max_run, 4);
    chk("b2b_flit_cnt", FLIT_CNT, 16'd5);
    chk("b2b_pkt_cnt", PKT_CNT, 16'd2);

    // Backpressure on VC0 with a VC1 ready glitch
    send_cmd(2'd2, 2'd1, 1'b0, 4'd2);
    hd = make_head(4'd2, 1'b0, MY_XPOS, MY_YPOS, 2'd2, 2'd1);
    @(negedge clk);
    CMD_VALID = 1'b0; WVALID = 1'b1; WDATA = 32'hB0B0_0001;
    for (int i = 0; i < 5; i++) begin
      IRDY = {i[0], 1'b0};
      #1;
      chk("bp_wready", WREADY, 0);
      chk("bp_ovalid", OVALID, 1);
      chk("bp_odata", ODATA, hd);
      chk("bp_no_xfer", FLIT_CNT, exp_flit);
      @(negedge clk);
    end
    IRDY = 2'b11; WVALID = 1'b0;
    send_word(32'hB0B0_0001, 1'b0, 1'b0);
    send_word(32'hB0B0_0002, 1'b1, 1'b0);
    go_idle();
    drain();
    chk("bp_flit_cnt", FLIT_CNT, 16'd8);
    chk("bp_pkt_cnt", PKT_CNT, 16'd3);

    // Mid-packet reset after head and first body word of LEN=4
    send_cmd(2'd3, 2'd3, 1'b1, 4'd4);
    send_word(32'hC0DE_0001, 1'b0, 1'b1);
    reset_on();
    @(negedge clk); #1;
    chk("mrst_ovalid", OVALID, 0);
    chk("mrst_busy", BUSY, 0);
    chk("mrst_flit_cnt", FLIT_CNT, 0);
    RST_ = 1'b1;
    #1;
    chk("mrst_idle_cmd_ready", CMD_READY, 1);
    send_pkt(2'd1, 2'd1, 1'b0, 4'd0, 32'h0);
    drain();
    chk("mrst_flit_cnt_after", FLIT_CNT, 16'd1);
    chk("mrst_pkt_cnt_after", PKT_CNT, 16'd1);

    // Counter wrap
    reset_on();
    @(negedge clk);
    RST_ = 1'b1;
    for (int i = 0; i < 65535; i++) begin
      logic [15:0] b;
      b = 16'(i);
      send_cmd(b[1:0], b[3:2], b[4], 4'd0);
    end
    go_idle();
    drain();
    chk("wrap_pre_flit", FLIT_CNT, 16'hFFFF);
    chk("wrap_pre_pkt", PKT_CNT, 16'hFFFF);
    send_pkt(2'd0, 2'd0, 1'b1, 4'd0, 32'h0);
    drain();
    chk("wrap_flit", FLIT_CNT, 16'h0000);
    chk("wrap_pkt", PKT_CNT, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
